// File: rtl/mem_arbiter.sv
// N-port byte-serial RAM/IO bus arbiter with variable-length reads/writes, rollback kill and UART stall.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting port wins.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_LEN   = 16,
    parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           rollback,
    input  logic [NUM_PORTS-1:0]           rollback_mask,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [31:0]                    mem_a,
    output logic                           mem_wr,
    input  logic                           io_buffer_full,
    input  logic [NUM_PORTS-1:0]           req_en,
    input  logic [NUM_PORTS-1:0]           req_wr,
    input  logic [NUM_PORTS*32-1:0]        req_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]     req_len,
    input  logic [NUM_PORTS*MAX_LEN*8-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           done,
    output logic [MAX_LEN*8-1:0]           rdata
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, COOLDOWN} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   cand;
    logic                   gnt_vld;
    logic [PW-1:0]          gnt_idx;
    logic                   g_wr;
    logic [31:0]            g_addr;
    logic [LEN_W-1:0]       g_len_raw, g_len;
    logic [MAX_LEN*8-1:0]   g_wdata;
    logic                   rd_kill, wr_stall, last;

    logic [PW-1:0]          port_q;
    logic [31:0]            addr_q;
    logic [LEN_W-1:0]       len_q, k_q;
    logic [MAX_LEN*8-1:0]   wdata_q;
    logic                   mem_wr_q;
    logic [NUM_PORTS-1:0]   done_q;
`ifdef MEM_ARB_RR_EN
    logic [PW-1:0]          ptr_q;
`endif

    assign cand     = req_en & ~(rollback ? rollback_mask : '0);
    assign rd_kill  = rollback && rollback_mask[port_q];
    assign wr_stall = (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign last     = (k_q == len_q);
    // Output registers freeze with the rest of the block; gating keeps a held byte/done pending.
    assign mem_wr   = mem_wr_q & rdy;
    assign done     = done_q & {NUM_PORTS{rdy}};

    always_comb begin
`ifdef MEM_ARB_RR_EN
        int unsigned j;
        j = 0;
`endif
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifdef MEM_ARB_RR_EN
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            j = (32'(ptr_q) + i) % NUM_PORTS;
            if (!gnt_vld && cand[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(j);
            end
        end
`else
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_vld && cand[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(i);
            end
        end
`endif
        g_wr      = req_wr[gnt_idx];
        g_addr    = req_addr[gnt_idx*32 +: 32];
        g_len_raw = req_len[gnt_idx*LEN_W +: LEN_W];
        g_len     = (g_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : g_len_raw;
        g_wdata   = req_wdata[gnt_idx*MAX_LEN*8 +: MAX_LEN*8];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (gnt_vld) state_d = g_wr ? WRITE : READ;
            READ:     if (rd_kill) state_d = IDLE;
                      else if (last) state_d = COOLDOWN;
            WRITE:    if (last) state_d = COOLDOWN;
            COOLDOWN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_q <= IDLE;
        else if (rdy) state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
            done_q   <= '0;
            rdata    <= '0;
            port_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            k_q      <= '0;
            wdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else if (rdy) begin
            done_q <= '0;
            case (state_q)
                IDLE: if (gnt_vld) begin
                    port_q  <= gnt_idx;
                    len_q   <= g_len;
                    k_q     <= '0;
                    wdata_q <= g_wdata;
                    addr_q  <= g_addr;
`ifdef MEM_ARB_RR_EN
                    ptr_q   <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
`endif
                    if (!g_wr) begin
                        rdata <= '0;
                        if (g_len != '0) begin
                            mem_a  <= g_addr;
                            addr_q <= g_addr + 32'd1;
                        end
                    end
                end
                READ: begin
                    if (rd_kill) begin
                        mem_a <= '0;
                    end else begin
                        // mem_din now carries the byte addressed in the previous cycle (index k_q-1)
                        for (int unsigned i = 0; i < MAX_LEN; i++)
                            if (k_q == LEN_W'(i + 1)) rdata[i*8 +: 8] <= mem_din;
                        if (last) begin
                            done_q[port_q] <= 1'b1;
                        end else begin
                            if ((k_q + LEN_W'(1)) < len_q) begin
                                mem_a  <= addr_q;
                                addr_q <= addr_q + 32'd1;
                            end else begin
                                mem_a <= '0;
                            end
                            k_q <= k_q + LEN_W'(1);
                        end
                    end
                end
                WRITE: begin
                    if (last) begin
                        mem_wr_q       <= 1'b0;
                        mem_a          <= '0;
                        done_q[port_q] <= 1'b1;
                    end else if (wr_stall) begin
                        mem_wr_q <= 1'b0;
                    end else begin
                        mem_a    <= addr_q;
                        mem_dout <= wdata_q[7:0];
                        mem_wr_q <= 1'b1;
                        wdata_q  <= wdata_q >> 8;
                        addr_q   <= addr_q + 32'd1;
                        k_q      <= k_q + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
